// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_write_arbiter
// Brief    : Shares the register file's single write port between the ALU
//            and the load unit. Each requester has its own FIFO; a
//            round-robin arbiter drains the FIFO heads into a registered
//            write port. Writes to x0 are dropped. A pending-write mask
//            covers every queued write plus the output stage.
// Options  : WB_ARB_STATS_EN - adds the 16-bit saturating conflictCount
//            output (edges where both FIFOs were non-empty).
// Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// Per-requester writeback FIFO with per-entry valid bits for the pending mask
// ----------------------------------------------------------------------------
module regfile_write_arbiter_fifo #(
  parameter int DEPTH      = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [ADDR_WIDTH-1:0]      push_rd,
  input  logic [DATA_WIDTH-1:0]      push_data,
  input  logic                       pop,
  output logic                       empty,
  output logic                       full,
  output logic [ADDR_WIDTH-1:0]      head_rd,
  output logic [DATA_WIDTH-1:0]      head_data,
  output logic [(2**ADDR_WIDTH)-1:0] pend_mask
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam int c_NREG  = 2**ADDR_WIDTH;

  logic [ADDR_WIDTH-1:0] r_rd   [DEPTH];
  logic [DATA_WIDTH-1:0] r_data [DEPTH];
  logic [DEPTH-1:0]      r_vld;
  logic [c_PTR_W-1:0]    r_wr_ptr;
  logic [c_PTR_W-1:0]    r_rd_ptr;
  logic [c_CNT_W-1:0]    r_count;

  // Exact full/empty from the registered count; no bypass paths.
  assign empty     = (r_count == '0);
  assign full      = (r_count == c_CNT_W'(DEPTH));
  assign head_rd   = r_rd[r_rd_ptr];
  assign head_data = r_data[r_rd_ptr];

  // Entry storage: written on push only, never needs a reset value.
  always_ff @(posedge clk) begin
    if (push) begin
      r_rd[r_wr_ptr]   <= push_rd;
      r_data[r_wr_ptr] <= push_data;
    end
  end

  // Pointers, count and entry-valid bits; pointers wrap modulo DEPTH.
  // Push and pop never touch the same slot: push needs !full, pop needs
  // !empty, so a shared slot would imply an empty FIFO being popped.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_vld    <= '0;
    end else begin
      if (push) begin
        r_vld[r_wr_ptr] <= 1'b1;
        r_wr_ptr        <= r_wr_ptr + c_PTR_W'(1);
      end
      if (pop) begin
        r_vld[r_rd_ptr] <= 1'b0;
        r_rd_ptr        <= r_rd_ptr + c_PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // One-hot OR of the destination of every occupied entry.
  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_vld[i]) begin
        pend_mask[r_rd[i]] = 1'b1;
      end
    end
  end

  logic unused_nreg;
  assign unused_nreg = (c_NREG == 0);

endmodule

// ----------------------------------------------------------------------------
// Top: two FIFOs, round-robin arbiter, registered write port
// ----------------------------------------------------------------------------
module regfile_write_arbiter #(
  parameter int DEPTH      = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       aluValid,
  output logic                       aluReady,
  input  logic [ADDR_WIDTH-1:0]      aluRd,
  input  logic [DATA_WIDTH-1:0]      aluData,
  input  logic                       memValid,
  output logic                       memReady,
  input  logic [ADDR_WIDTH-1:0]      memRd,
  input  logic [DATA_WIDTH-1:0]      memData,
  output logic                       regWrite,
  output logic [ADDR_WIDTH-1:0]      writeRegister,
  output logic [DATA_WIDTH-1:0]      writeData,
  output logic [(2**ADDR_WIDTH)-1:0] pendingMask
`ifdef WB_ARB_STATS_EN
  ,
  output logic [15:0]                conflictCount
`endif
);

  localparam int c_NREG = 2**ADDR_WIDTH;

  typedef enum logic [0:0] {
    GRANT_ALU = 1'b0,
    GRANT_MEM = 1'b1
  } grant_e;

  grant_e                r_last_grant;
  logic                  w_alu_push;
  logic                  w_mem_push;
  logic                  w_alu_empty;
  logic                  w_mem_empty;
  logic                  w_alu_full;
  logic                  w_mem_full;
  logic [ADDR_WIDTH-1:0] w_alu_head_rd;
  logic [ADDR_WIDTH-1:0] w_mem_head_rd;
  logic [DATA_WIDTH-1:0] w_alu_head_data;
  logic [DATA_WIDTH-1:0] w_mem_head_data;
  logic [c_NREG-1:0]     w_alu_pend;
  logic [c_NREG-1:0]     w_mem_pend;
  logic [c_NREG-1:0]     w_out_pend;
  logic                  w_grant_alu;
  logic                  w_grant_mem;

  // Ready is a pure function of the registered count.
  assign aluReady = !w_alu_full;
  assign memReady = !w_mem_full;

  // An accepted x0 write is consumed here and never enters a FIFO.
  assign w_alu_push = aluValid && aluReady && (aluRd != '0);
  assign w_mem_push = memValid && memReady && (memRd != '0);

  regfile_write_arbiter_fifo #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_alu_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (w_alu_push),
    .push_rd   (aluRd),
    .push_data (aluData),
    .pop       (w_grant_alu),
    .empty     (w_alu_empty),
    .full      (w_alu_full),
    .head_rd   (w_alu_head_rd),
    .head_data (w_alu_head_data),
    .pend_mask (w_alu_pend)
  );

  regfile_write_arbiter_fifo #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (w_mem_push),
    .push_rd   (memRd),
    .push_data (memData),
    .pop       (w_grant_mem),
    .empty     (w_mem_empty),
    .full      (w_mem_full),
    .head_rd   (w_mem_head_rd),
    .head_data (w_mem_head_data),
    .pend_mask (w_mem_pend)
  );

  // Round-robin grant: a lone requester always wins; on contention the
  // requester that did not win last time is served.
  always_comb begin
    w_grant_alu = 1'b0;
    w_grant_mem = 1'b0;
    if (!w_alu_empty && (w_mem_empty || (r_last_grant == GRANT_MEM))) begin
      w_grant_alu = 1'b1;
    end else if (!w_mem_empty) begin
      w_grant_mem = 1'b1;
    end
  end

  // Remember the last winner; reset favours the ALU on the first contest.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_grant <= GRANT_MEM;
    end else if (w_grant_alu) begin
      r_last_grant <= GRANT_ALU;
    end else if (w_grant_mem) begin
      r_last_grant <= GRANT_MEM;
    end
  end

  // Registered write port: load the granted head, else drop the enable and
  // hold index/data.
  always_ff @(posedge clk) begin
    if (reset) begin
      regWrite      <= 1'b0;
      writeRegister <= '0;
      writeData     <= '0;
    end else if (w_grant_alu) begin
      regWrite      <= 1'b1;
      writeRegister <= w_alu_head_rd;
      writeData     <= w_alu_head_data;
    end else if (w_grant_mem) begin
      regWrite      <= 1'b1;
      writeRegister <= w_mem_head_rd;
      writeData     <= w_mem_head_data;
    end else begin
      regWrite      <= 1'b0;
    end
  end

  // The write currently on the port is still pending until the file takes it.
  always_comb begin
    w_out_pend = '0;
    if (regWrite) begin
      w_out_pend[writeRegister] = 1'b1;
    end
  end

  assign pendingMask = w_alu_pend | w_mem_pend | w_out_pend;

`ifdef WB_ARB_STATS_EN
  logic [15:0] r_conflict_cnt;

  // Count edges with both FIFOs non-empty, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_conflict_cnt <= '0;
    end else if (!w_alu_empty && !w_mem_empty && (r_conflict_cnt != 16'hFFFF)) begin
      r_conflict_cnt <= r_conflict_cnt + 16'd1;
    end
  end

  assign conflictCount = r_conflict_cnt;
`else
  // No conflict statistics in this build.
`endif

endmodule

`default_nettype wire

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the register file's single synchronous write port between two writeback requesters: the ALU and the load unit ("mem").
- Each requester has its own small FIFO; a round-robin arbiter drains the FIFOs into a registered write port (regWrite / writeRegister / writeData).
- Writes to x0 are dropped.
- Exports a pending-write mask so issue logic can detect hazards against writes still queued.

Parameters:
- DEPTH, 2: entries per requester FIFO; power of two, at least 2.
- DATA_WIDTH, 32: width of the write data.
- ADDR_WIDTH, 5: register index width; the register file has 2**ADDR_WIDTH registers.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- aluValid  in  1  ALU write request valid.
- aluReady  out  1  ALU FIFO can accept; equals !aluFull.
- aluRd  in  ADDR_WIDTH  ALU destination register.
- aluData  in  DATA_WIDTH  ALU write data.
- memValid  in  1  load-unit write request valid.
- memReady  out  1  load-unit FIFO can accept; equals !memFull.
- memRd  in  ADDR_WIDTH  load-unit destination register.
- memData  in  DATA_WIDTH  load-unit write data.
- regWrite  out  1  register file write enable (registered).
- writeRegister  out  ADDR_WIDTH  register file write index (registered).
- writeData  out  DATA_WIDTH  register file write data (registered).
- pendingMask  out  2**ADDR_WIDTH  bit r is set while any write to register r is queued or is on the output stage.

Behaviour:
- Reset (synchronous, active-high):
  - Both FIFOs emptied; queued writes are discarded, including when reset arrives mid-operation.
  - regWrite=0, writeRegister=0, writeData=0.
  - lastGrant=MEM, so the ALU wins the first contested cycle.
  - pendingMask=0; aluReady=1 and memReady=1 in the cycle after reset deasserts.
- Accept:
  - A request is accepted at an edge where valid && ready.
  - Ready depends only on the registered FIFO count; there is no enqueue bypass when the FIFO is full, even if it is popped in the same cycle.
- x0 filter: an accepted request with rd==0 is consumed (ready is honoured) but is not enqueued. It never reaches regWrite and never sets pendingMask.
- Arbitration is combinational each cycle on the FIFO heads:
  - Neither FIFO non-empty: no grant; regWrite=0 next cycle.
  - Only one FIFO non-empty: that FIFO is granted.
  - Both non-empty: the requester other than lastGrant is granted; lastGrant updates on every grant.
- Pop: at the edge, the granted head is popped into the output registers and regWrite is set to 1. Otherwise regWrite is cleared and writeRegister/writeData hold their values.
- Latency:
  - An entry accepted into an empty FIFO at edge k is on the write port between edges k+1 and k+2.
  - The register file captures it at edge k+2.
- Throughput: one write per cycle sustained.
- Ordering:
  - Each requester's FIFO order is preserved.
  - Order across requesters follows the round-robin grant only.
  - Upstream uses pendingMask to avoid cross-requester WAW hazards.
- pendingMask:
  - Combinational OR of the one-hot decodes of rd for every valid FIFO entry plus the output stage (when regWrite=1).
  - A bit clears in the cycle after its last pending write has been presented on the write port.
- FIFO pointers wrap modulo DEPTH; the counts range 0..DEPTH.
- Full and empty are exact: with DEPTH=2, a third ALU request with no pops stalls (aluReady=0).

Optional Feature:
- Macro WB_ARB_STATS_EN.
- Defined:
  - Adds output port conflictCount [15:0].
  - Increments at each edge where both FIFOs are non-empty; saturates at 16'hFFFF.
  - Cleared by reset.
- Undefined: the port and its counter do not exist; all other behaviour is identical.

Test Plan:
- Single write: aluValid=1, aluRd=5, aluData=32'hDEADBEEF for one cycle after reset. Required: regWrite=1 with writeRegister=5 and writeData=32'hDEADBEEF exactly one cycle after acceptance. pendingMask[5] is set from the cycle after acceptance until the cycle after regWrite drops.
- Contention: aluRd=1 (data 32'h11) and memRd=2 (data 32'h22) enqueued in the same cycle, twice. Required: the write-port sequence is x1, x2, x1, x2 (ALU first after reset), with no idle cycles.
- Backpressure: 3 back-to-back ALU requests while the load unit is kept granted (DEPTH=2). Required: aluReady=0 on the third; nothing is lost; the three writes emerge in order.
- x0 drop: memValid=1, memRd=0, memData=32'hFFFFFFFF. Required: memReady=1; regWrite never asserts; pendingMask stays 0.
- Reset mid-operation: 2 entries queued in each FIFO, then reset pulsed for 1 cycle. Required: regWrite=0 and pendingMask=0 from the next cycle; no stale writes afterwards; both ready outputs=1.
- Stats (WB_ARB_STATS_EN defined): both FIFOs kept non-empty for 10 edges. Required: conflictCount=10; reset returns it to 0.
